pimt_operand_sync: RTL and testbench
====================================

Name: pimt_operand_sync

Overview:
Operand transmitter for the pimt product stage.
- Accepts three independently arriving valid-only double-precision operand streams: alpha, phi and powsub4.
- Buffers each stream in its own FIFO.
- Issues alpha/phi as one aligned single-cycle valid pair into the first multiplier.
- Re-times powsub4 by the multiplier latency, so its valid coincides with the first multiplier's result valid at the second multiplier.

Parameters:
- DW, 64, operand width in bits (IEEE-754 double).
- DEPTH, 4, entries per operand FIFO; power of two, at least 2.
- MUL_LAT, 8, cycles from first-multiplier input valid to its result valid; at least 1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- alpha_in  in  DW  alpha operand.
- alpha_in_vld  in  1  alpha write strobe.
- phi_in  in  DW  phi operand.
- phi_in_vld  in  1  phi write strobe.
- powsub4_in  in  DW  powsub4 operand.
- powsub4_in_vld  in  1  powsub4 write strobe.
- issue_en  in  1  downstream permits an issue this cycle.
- ovf_clr  in  1  clears the sticky overflow flags.
- alpha_r  out  DW  issued alpha.
- alpha_r_vld  out  1  issue pulse for alpha.
- phi_r  out  DW  issued phi.
- phi_r_vld  out  1  issue pulse for phi; always equal to alpha_r_vld.
- powsub4  out  DW  powsub4, delayed.
- powsub4_vld  out  1  issue pulse delayed MUL_LAT cycles.
- full  out  3  per-FIFO full flags: {powsub4, phi, alpha}.
- ovf  out  3  sticky per-FIFO overflow flags, same bit order as full.
- busy  out  1  any FIFO non-empty or any issue still in the delay line.
- issue_cnt  out  32  count of issued tuples (see Optional Feature).

Behaviour:
- Reset:
  - Clock is clk; reset is rst_n, asynchronous, active-low.
  - Reset clears all FIFO pointers and counts, the delay line, and ovf.
  - All outputs are 0 during reset and after release; full=0, busy=0.
  - Reset mid-operation discards all buffered and in-flight operands; no valid is emitted for them.
- FIFOs:
  - Each FIFO holds DEPTH entries and has a count of width log2(DEPTH)+1.
  - Read and write pointers are log2(DEPTH) bits and wrap naturally.
  - A write strobe while the FIFO is not full stores the data.
  - A write strobe while full and no issue this cycle drops the data and sets that FIFO's ovf bit.
  - A write strobe while full in the same cycle as an issue is accepted; the count is unchanged.
  - A write to an empty FIFO is readable for issue on the next cycle; there is no fall-through.
- Issue condition: issue = issue_en & all three FIFOs non-empty.
  - On an issue, one entry is popped from each FIFO simultaneously.
  - Next cycle: alpha_r and phi_r are registered with the popped values and alpha_r_vld = phi_r_vld = 1 for exactly one cycle.
  - Back-to-back issues every cycle are allowed.
  - alpha_r and phi_r hold their last value when vld=0.
- Delay line:
  - The popped powsub4 value and valid enter a MUL_LAT-stage shift register.
  - powsub4_vld is asserted exactly MUL_LAT cycles after the corresponding alpha_r_vld.
  - The line is fully pipelined; up to MUL_LAT tuples can be in flight.
  - It ignores issue_en; the downstream multipliers are always ready.
- Overflow clear:
  - ovf_clr clears ovf on the next edge.
  - If ovf_clr and a new overflow occur in the same cycle, the set wins.
- full and busy are combinational from the registered state.
- No other backpressure exists; inputs are never stalled.

Optional Feature:
- Macro: PIMT_SYNC_CNT_EN.
- Defined:
  - issue_cnt increments by 1 on each issue cycle.
  - It wraps from 2^32-1 to 0.
  - It is reset to 0 by rst_n.
- Undefined:
  - The counter logic is not synthesised.
  - issue_cnt is tied to 0.

Test Plan:
- Aligned issue:
  - Stimulus: reset, issue_en=1; alpha=3.0 at cycle 0, phi=2.0 at cycle 2, powsub4=5.0 at cycle 5.
  - Required: a single alpha_r_vld/phi_r_vld pulse at cycle 7 with 3.0/2.0; powsub4_vld with 5.0 at cycle 7+MUL_LAT; busy=0 afterwards.
- Streaming:
  - Stimulus: all three valids high for 10 consecutive cycles with values 1.0..10.0, issue_en=1.
  - Required: 10 consecutive vld pulses in order; each powsub4 lags its pair by MUL_LAT; ovf=0.
- Overflow:
  - Stimulus: issue_en=0, alpha written 5 times with DEPTH=4.
  - Required: full[0]=1 after the 4th write; ovf[0]=1 after the 5th; the first 4 values are issued later.
  - Then: ovf_clr pulse gives ovf=0.
- Full with simultaneous read and write:
  - Stimulus: all FIFOs full; assert issue_en and an alpha write in the same cycle.
  - Required: write accepted, ovf stays 0, alpha count stays 4.
- Reset mid-flight:
  - Stimulus: assert rst_n=0 two cycles after an issue.
  - Required: powsub4_vld never pulses for that tuple; all outputs read 0.
- Counter (with PIMT_SYNC_CNT_EN):
  - Stimulus: preload via 3 issues.
  - Required: issue_cnt=3; with the macro undefined, issue_cnt=0.

Source files
------------

// File: rtl/pimt_operand_sync.sv
// pimt_operand_sync: collects the alpha, phi and powsub4 operand streams for
// the pimt product stage. Each stream is buffered in its own FIFO. alpha and
// phi are issued as one aligned pair into the first multiplier. powsub4 is
// delayed so that it meets that multiplier's result at the second multiplier.
// Optional feature macro: PIMT_SYNC_CNT_EN enables the issued-tuple counter.
// When the macro is undefined, issue_cnt is tied to 0.
module pimt_operand_sync #(
    parameter int DW      = 64,
    parameter int DEPTH   = 4,
    parameter int MUL_LAT = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] alpha_in,
    input  logic          alpha_in_vld,
    input  logic [DW-1:0] phi_in,
    input  logic          phi_in_vld,
    input  logic [DW-1:0] powsub4_in,
    input  logic          powsub4_in_vld,
    input  logic          issue_en,
    input  logic          ovf_clr,
    output logic [DW-1:0] alpha_r,
    output logic          alpha_r_vld,
    output logic [DW-1:0] phi_r,
    output logic          phi_r_vld,
    output logic [DW-1:0] powsub4,
    output logic          powsub4_vld,
    output logic [2:0]    full,
    output logic [2:0]    ovf,
    output logic          busy,
    output logic [31:0]   issue_cnt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int NF = 3;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // FIFO index 0 = alpha, 1 = phi, 2 = powsub4 (matches full/ovf bit order)
    logic [DW-1:0] wr_data [NF];
    logic [DW-1:0] rd_data [NF];
    logic [NF-1:0] wr_vld;
    logic [NF-1:0] not_empty;
    logic [NF-1:0] full_int;
    logic [NF-1:0] ovf_int;
    logic          issue;

    assign wr_data[0] = alpha_in;
    assign wr_data[1] = phi_in;
    assign wr_data[2] = powsub4_in;
    assign wr_vld     = {powsub4_in_vld, phi_in_vld, alpha_in_vld};

    // All three FIFOs must hold an operand before a tuple can leave together
    assign issue = issue_en & (&not_empty);

    generate
        for (genvar gi = 0; gi < NF; gi++) begin : g_fifo
            logic [DW-1:0] mem [DEPTH];
            logic [AW-1:0] wr_ptr_reg;
            logic [AW-1:0] rd_ptr_reg;
            logic [CW-1:0] count_reg;
            logic          ovf_bit_reg;
            logic          accept;
            logic          drop;

            assign full_int[gi]  = (count_reg == DEPTH_C);
            assign not_empty[gi] = (count_reg != '0);
            // A full FIFO still accepts a write if a pop frees a slot on the same edge
            assign accept        = wr_vld[gi] & (~full_int[gi] | issue);
            assign drop          = wr_vld[gi] & full_int[gi] & ~issue;
            assign rd_data[gi]   = mem[rd_ptr_reg];
            assign ovf_int[gi]   = ovf_bit_reg;

            // Storage array is left unreset so that it maps onto RAM
            always_ff @(posedge clk) begin
                if (accept) begin
                    mem[wr_ptr_reg] <= wr_data[gi];
                end
            end

            // Pointers, occupancy and the sticky overflow flag (a new drop wins over a clear)
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    wr_ptr_reg  <= '0;
                    rd_ptr_reg  <= '0;
                    count_reg   <= '0;
                    ovf_bit_reg <= 1'b0;
                end else begin
                    if (accept) begin
                        wr_ptr_reg <= wr_ptr_reg + AW'(1);
                    end
                    if (issue) begin
                        rd_ptr_reg <= rd_ptr_reg + AW'(1);
                    end
                    if (accept && !issue) begin
                        count_reg <= count_reg + CW'(1);
                    end else if (!accept && issue) begin
                        count_reg <= count_reg - CW'(1);
                    end
                    if (drop) begin
                        ovf_bit_reg <= 1'b1;
                    end else if (ovf_clr) begin
                        ovf_bit_reg <= 1'b0;
                    end
                end
            end
        end
    endgenerate

    logic [DW-1:0] alpha_r_reg;
    logic [DW-1:0] phi_r_reg;
    logic [DW-1:0] pop_ps_reg;
    logic          issue_vld_reg;

    // Register the popped tuple; alpha/phi hold their value between issues
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alpha_r_reg   <= '0;
            phi_r_reg     <= '0;
            pop_ps_reg    <= '0;
            issue_vld_reg <= 1'b0;
        end else begin
            issue_vld_reg <= issue;
            if (issue) begin
                alpha_r_reg <= rd_data[0];
                phi_r_reg   <= rd_data[1];
                pop_ps_reg  <= rd_data[2];
            end
        end
    end

    logic [DW-1:0]      dly_data_reg [MUL_LAT];
    logic [MUL_LAT-1:0] dly_vld_reg;

    // MUL_LAT-stage shift line behind the issue register. It aligns powsub4 with the first multiplier result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MUL_LAT; i++) begin
                dly_data_reg[i] <= '0;
            end
            dly_vld_reg <= '0;
        end else begin
            dly_data_reg[0] <= pop_ps_reg;
            dly_vld_reg[0]  <= issue_vld_reg;
            for (int i = 1; i < MUL_LAT; i++) begin
                dly_data_reg[i] <= dly_data_reg[i-1];
                dly_vld_reg[i]  <= dly_vld_reg[i-1];
            end
        end
    end

`ifdef PIMT_SYNC_CNT_EN
    logic [31:0] issue_cnt_reg;

    // Free-running count of issued tuples, wrapping at 2^32
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt_reg <= '0;
        end else if (issue) begin
            issue_cnt_reg <= issue_cnt_reg + 32'd1;
        end
    end

    assign issue_cnt = issue_cnt_reg;
`else
    assign issue_cnt = '0;
`endif

    assign alpha_r     = alpha_r_reg;
    assign alpha_r_vld = issue_vld_reg;
    assign phi_r       = phi_r_reg;
    assign phi_r_vld   = issue_vld_reg;
    assign powsub4     = dly_data_reg[MUL_LAT-1];
    assign powsub4_vld = dly_vld_reg[MUL_LAT-1];
    assign full        = full_int;
    assign ovf         = ovf_int;
    assign busy        = (|not_empty) | issue_vld_reg | (|dly_vld_reg);

endmodule

// File: tb/tb_pimt_operand_sync.sv
// Testbench for pimt_operand_sync. A queue-based reference model predicts every output on every cycle.
module tb_pimt_operand_sync;
    localparam int DW      = 64;
    localparam int DEPTH   = 4;
    localparam int MUL_LAT = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] alpha_in = '0, phi_in = '0, powsub4_in = '0;
    logic          alpha_in_vld = 1'b0, phi_in_vld = 1'b0, powsub4_in_vld = 1'b0;
    logic          issue_en = 1'b0, ovf_clr = 1'b0;
    logic [DW-1:0] alpha_r, phi_r, powsub4;
    logic          alpha_r_vld, phi_r_vld, powsub4_vld, busy;
    logic [2:0]    full, ovf;
    logic [31:0]   issue_cnt;

    pimt_operand_sync #(.DW(DW), .DEPTH(DEPTH), .MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .alpha_in(alpha_in), .alpha_in_vld(alpha_in_vld),
        .phi_in(phi_in), .phi_in_vld(phi_in_vld),
        .powsub4_in(powsub4_in), .powsub4_in_vld(powsub4_in_vld),
        .issue_en(issue_en), .ovf_clr(ovf_clr),
        .alpha_r(alpha_r), .alpha_r_vld(alpha_r_vld),
        .phi_r(phi_r), .phi_r_vld(phi_r_vld),
        .powsub4(powsub4), .powsub4_vld(powsub4_vld),
        .full(full), .ovf(ovf), .busy(busy), .issue_cnt(issue_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: plain queues for the FIFOs, a list of due powsub4 events
    typedef struct {
        int          due;
        logic [63:0] val;
    } pend_t;

    logic [63:0] qa[$], qp[$], qs[$];
    pend_t       pend[$];
    logic [63:0] m_alpha = '0, m_phi = '0, m_ps = '0;
    logic        m_vld = 1'b0, m_psvld = 1'b0;
    logic [2:0]  m_ovf = '0;
    logic [31:0] m_cnt = '0;
    int          n = 0;
    int          vld_seen = 0, ps_seen = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [31:0] exp_cnt();
`ifdef PIMT_SYNC_CNT_EN
        return m_cnt;
`else
        return 32'd0;
`endif
    endfunction

    task automatic check_outputs();
        logic [2:0] m_full;
        logic       m_busy;
        m_full = {qs.size() == DEPTH, qp.size() == DEPTH, qa.size() == DEPTH};
        m_busy = (qa.size() > 0) || (qp.size() > 0) || (qs.size() > 0) || (pend.size() > 0) || m_psvld;
        chk("alpha_r_vld", 64'(alpha_r_vld), 64'(m_vld));
        chk("phi_r_vld", 64'(phi_r_vld), 64'(m_vld));
        chk("alpha_r", alpha_r, m_alpha);
        chk("phi_r", phi_r, m_phi);
        chk("powsub4_vld", 64'(powsub4_vld), 64'(m_psvld));
        if (m_psvld) chk("powsub4", powsub4, m_ps);
        chk("full", 64'(full), 64'(m_full));
        chk("ovf", 64'(ovf), 64'(m_ovf));
        chk("busy", 64'(busy), 64'(m_busy));
        chk("issue_cnt", 64'(issue_cnt), 64'(exp_cnt()));
    endtask

    // One clock cycle: drive inputs, advance the model, check after the edge
    task automatic step(input logic av, input logic [63:0] ad, input logic pv, input logic [63:0] pd,
                        input logic sv, input logic [63:0] sd, input logic ie, input logic clr);
        bit         iss, fa, fp, fs;
        logic [2:0] set;
        pend_t      p;
        alpha_in_vld = av; alpha_in = ad;
        phi_in_vld = pv; phi_in = pd;
        powsub4_in_vld = sv; powsub4_in = sd;
        issue_en = ie; ovf_clr = clr;
        iss = ie && qa.size() > 0 && qp.size() > 0 && qs.size() > 0;
        fa = qa.size() == DEPTH; fp = qp.size() == DEPTH; fs = qs.size() == DEPTH;
        if (iss) begin
            m_alpha = qa.pop_front();
            m_phi   = qp.pop_front();
            p.due   = n + 1 + MUL_LAT;
            p.val   = qs.pop_front();
            pend.push_back(p);
            m_cnt++;
        end
        m_vld = iss;
        set = '0;
        if (av) begin if (!fa || iss) qa.push_back(ad); else set[0] = 1'b1; end
        if (pv) begin if (!fp || iss) qp.push_back(pd); else set[1] = 1'b1; end
        if (sv) begin if (!fs || iss) qs.push_back(sd); else set[2] = 1'b1; end
        m_ovf = set | (clr ? 3'b000 : m_ovf);
        @(posedge clk);
        n++;
        #1;
        m_psvld = 1'b0;
        if (pend.size() > 0 && pend[0].due == n) begin
            p = pend.pop_front();
            m_psvld = 1'b1;
            m_ps = p.val;
        end
        if (alpha_r_vld) begin
            vld_seen++;
            $display("issue cycle=%0d alpha=%h phi=%h", n, alpha_r, phi_r);
        end
        if (powsub4_vld) ps_seen++;
        check_outputs();
    endtask

    task automatic idle(input int cycles, input logic ie);
        for (int i = 0; i < cycles; i++) step(0, '0, 0, '0, 0, '0, ie, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        alpha_in_vld = 0; phi_in_vld = 0; powsub4_in_vld = 0; issue_en = 0; ovf_clr = 0;
        qa.delete(); qp.delete(); qs.delete(); pend.delete();
        m_alpha = '0; m_phi = '0; m_ps = '0; m_vld = 0; m_psvld = 0; m_ovf = '0; m_cnt = '0;
        #1;
        chk("rst_alpha_r_vld", 64'(alpha_r_vld), 64'd0);
        chk("rst_powsub4_vld", 64'(powsub4_vld), 64'd0);
        repeat (2) @(posedge clk);
        n += 2;
        #1;
        chk("rst_powsub4", powsub4, 64'd0);
        check_outputs();
        rst_n = 1'b1;
    endtask

    initial begin
        int first_vld, first_ps, v0, p0;
        logic [63:0] r;

        // Reset state
        do_reset();
        idle(2, 1);

        // Aligned issue: alpha at cycle 0, phi at cycle 2, powsub4 at cycle 5
        first_vld = -1; first_ps = -1;
        for (int k = 0; k < 20; k++) begin
            step(k == 0, $realtobits(3.0), k == 2, $realtobits(2.0), k == 5, $realtobits(5.0), 1, 0);
            if (alpha_r_vld && first_vld < 0) first_vld = k + 1;
            if (powsub4_vld && first_ps < 0) first_ps = k + 1;
        end
        chk("aligned_vld_cycle", 64'(first_vld), 64'd7);
        chk("aligned_ps_cycle", 64'(first_ps), 64'(7 + MUL_LAT));
        chk("aligned_busy_end", 64'(busy), 64'd0);

        // Streaming: 1.0..10.0 on all three streams back to back
        v0 = vld_seen; p0 = ps_seen;
        for (int i = 0; i < 10; i++) begin
            r = $realtobits(real'(i + 1));
            step(1, r, 1, r, 1, r, 1, 0);
        end
        idle(MUL_LAT + 4, 1);
        chk("stream_pairs", 64'(vld_seen - v0), 64'd10);
        chk("stream_ps", 64'(ps_seen - p0), 64'd10);
        chk("stream_ovf", 64'(ovf), 64'd0);

        // Overflow: five alpha writes with issue disabled
        for (int i = 0; i < 5; i++) begin
            step(1, {$urandom, $urandom}, 0, '0, 0, '0, 0, 0);
            if (i == 3) chk("ovf_full_after4", 64'(full[0]), 64'd1);
        end
        chk("ovf_set_after5", 64'(ovf[0]), 64'd1);
        step(0, '0, 0, '0, 0, '0, 0, 1);
        chk("ovf_cleared", 64'(ovf), 64'd0);

        // Fill phi and powsub4, then read and write a full alpha FIFO together
        for (int i = 0; i < DEPTH; i++) step(0, '0, 1, {$urandom, $urandom}, 1, {$urandom, $urandom}, 0, 0);
        chk("all_full", 64'(full), 64'h7);
        step(1, {$urandom, $urandom}, 0, '0, 0, '0, 1, 0);
        chk("rw_full_ovf", 64'(ovf), 64'd0);
        chk("rw_full_flags", 64'(full), 64'h1);
        idle(DEPTH + MUL_LAT + 4, 1);

        // Reset two cycles after an issue: the tuple must vanish
        step(1, {$urandom, $urandom}, 1, {$urandom, $urandom}, 1, {$urandom, $urandom}, 1, 0);
        step(0, '0, 0, '0, 0, '0, 1, 0);
        step(0, '0, 0, '0, 0, '0, 1, 0);
        p0 = ps_seen;
        do_reset();
        idle(MUL_LAT + 4, 1);
        chk("midflight_no_ps", 64'(ps_seen - p0), 64'd0);

        // Counter after three issues
        for (int i = 0; i < 3; i++) step(1, {$urandom, $urandom}, 1, {$urandom, $urandom}, 1, {$urandom, $urandom}, 1, 0);
        idle(2, 1);
`ifdef PIMT_SYNC_CNT_EN
        chk("issue_cnt_3", 64'(issue_cnt), 64'd3);
`else
        chk("issue_cnt_tied", 64'(issue_cnt), 64'd0);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) < 40, {$urandom, $urandom},
                 $urandom_range(0, 99) < 40, {$urandom, $urandom},
                 $urandom_range(0, 99) < 40, {$urandom, $urandom},
                 $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 5);
        end
        idle(DEPTH + MUL_LAT + 4, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog so that the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
